mycircuit: RTL and testbench
============================

Name: mycircuit

Overview:
- Stereo audio sample processor between the board audio-codec core's read FIFO and write FIFO.
- Pulls one left/right sample pair when the codec has input available.
- Passes each channel through a power-of-two-length moving-average (boxcar) low-pass filter.
- Pushes the filtered pair back to the codec.
- One instance sits at top level, wired directly to the audio core handshake.

Parameters:
- DATA_W, 24: sample width, two's-complement signed.
- TAPS_LOG2, 2: log2 of filter length; TAPS = 2**TAPS_LOG2 (default 4).

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- read_ready  input  1  codec input FIFO holds a sample pair.
- write_ready  input  1  codec output FIFO can accept a sample pair.
- read  output  1  one-cycle pulse that consumes the current readdata pair.
- write  output  1  one-cycle pulse that pushes the writedata pair.
- readdata_left  input  DATA_W  left input sample.
- readdata_right  input  DATA_W  right input sample.
- writedata_left  output  DATA_W  filtered left sample.
- writedata_right  output  DATA_W  filtered right sample.

Behaviour:
- Reset, asynchronous while reset=0:
  - state=IDLE; read=0; write=0; writedata_*=0.
  - Both delay lines, both running sums and the write pointer cleared to 0.
- FSM states: IDLE, READ, CALC, WAIT_W, WRITE. read and write are decoded from state only (Moore outputs, registered state, no glitches).
  - IDLE: if read_ready=1, go to READ; otherwise stay.
  - READ: read=1 for exactly one cycle. readdata_left/right are captured into input registers on this edge. Always go to CALC.
  - CALC, per channel:
    - sum <= sum + x - line[ptr]; line[ptr] <= x.
    - writedata <= (sum + x - line[ptr]) >>> TAPS_LOG2 (arithmetic shift, truncation toward -inf).
    - ptr <= ptr+1, wrapping modulo TAPS.
    - Go to WAIT_W.
  - WAIT_W: if write_ready=1, go to WRITE; otherwise hold. writedata stays stable indefinitely.
  - WRITE: write=1 for exactly one cycle; writedata_* are valid and stable. Go to IDLE.
- read and write are never high in the same cycle. At most one read per write: the next read is taken only after the previous write completes.
- Latency: read pulse to write pulse is minimum 3 cycles (READ, CALC, WAIT_W at one cycle each, then WRITE). Each sample pair takes at least 5 cycles.
- Widths: running sum is DATA_W+TAPS_LOG2 bits, signed, and never overflows. Output is the low DATA_W bits after the shift; the result always fits.
- Filter start-up: the first TAPS-1 outputs average against zero history.
- Signed inputs: sign-extended into the sum, e.g. input -8 with TAPS=4 and empty history gives -2.
- read_ready or write_ready dropping while waiting: the FSM simply stays in IDLE or WAIT_W. Ready inputs are ignored in READ, CALC and WRITE.
- reset asserted mid-operation (any state): immediate return to reset values; any partially processed sample is discarded.

Optional Feature:
- Macro MYCIRCUIT_ROUND_EN.
- Defined: CALC adds 2**(TAPS_LOG2-1) to the new sum before the arithmetic shift, rounding half up; the stored running sum is left unrounded.
- Undefined: plain truncating shift as specified above.
- FSM, timing and ports are identical in both builds.

Decomposition:
- Package mycircuit_pkg holds:
  - localparams DATA_W_DEF=24 and TAPS_LOG2_DEF=2;
  - the FSM state enum typedef (IDLE, READ, CALC, WAIT_W, WRITE);
  - a signed sample typedef.
- One natural sub-module, mycircuit_avg_chan: delay line, running sum and shifted output for one channel, with enable=CALC and shared ptr. It is instantiated twice (left, right).
- FSM and pointer stay in mycircuit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with read_ready=1 -> read=0, write=0, writedata_*=0. Release -> first read pulse 1 cycle after the first edge with read_ready=1.
- Steady stream: read_ready=write_ready=1, both channels fed repeating 64,128,192,256 -> outputs 16, 48, 96, 160, then 160 on every further write. Exactly one read and one write pulse per pair, with 5-cycle spacing.
- Back-pressure: write_ready=0 for 20 cycles after CALC -> write stays 0, writedata holds its value, no new read. On write_ready=1 -> a single write pulse, then a read.
- Channel independence and sign: left fed constant 1000, right fed constant -8 -> after 4 samples left=1000, right=-8; first outputs are left=250, right=-2.
- Truncation versus rounding: 4 samples of value 3 from zero history -> first output 0 without MYCIRCUIT_ROUND_EN, 1 with it.
- Reset mid-stream: assert reset during WAIT_W after output 160 -> outputs 0 immediately. Feeding 64 afterwards gives 16, proving the history was cleared.

Source files
------------

// File: rtl/mycircuit_pkg.sv
// Shared types and defaults for the stereo boxcar sample processor.
// Optional build macro: MYCIRCUIT_ROUND_EN (round-half-up output instead of truncation).
package mycircuit_pkg;

    localparam int DATA_W_DEF    = 24;
    localparam int TAPS_LOG2_DEF = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        CALC   = 3'd2,
        WAIT_W = 3'd3,
        WRITE  = 3'd4
    } state_e;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    // Half of one output LSB expressed in running-sum units.
    function automatic int round_bias(input int taps_log2);
        return (taps_log2 > 0) ? (1 << (taps_log2 - 1)) : 0;
    endfunction

endpackage

// File: rtl/mycircuit_avg_chan.sv
// One channel of the moving-average filter: delay line, running sum, output register.
// Build macro MYCIRCUIT_ROUND_EN selects round-half-up on the output shift.
module mycircuit_avg_chan
    import mycircuit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAPS_LOG2 = TAPS_LOG2_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [TAPS_LOG2-1:0] ptr_i,
    input  logic [DATA_W-1:0]    x_i,
    output logic [DATA_W-1:0]    y_o
);

    localparam int TAPS  = 1 << TAPS_LOG2;
    localparam int SUM_W = DATA_W + TAPS_LOG2;

    logic [DATA_W-1:0]       line_q [TAPS];
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] x_ext_s;
    logic signed [SUM_W-1:0] old_ext_s;
    logic signed [SUM_W-1:0] res_s;
    logic [DATA_W-1:0]       old_s;
    logic [DATA_W-1:0]       y_q;
    logic [DATA_W-1:0]       y_d;

    assign old_s     = line_q[ptr_i];
    assign x_ext_s   = {{TAPS_LOG2{x_i[DATA_W-1]}}, x_i};
    assign old_ext_s = {{TAPS_LOG2{old_s[DATA_W-1]}}, old_s};

`ifdef MYCIRCUIT_ROUND_EN
    localparam logic signed [SUM_W-1:0] BIAS = SUM_W'(round_bias(TAPS_LOG2));
`endif

    // New running sum and the shifted output derived from it; the stored sum is never rounded.
    always_comb begin
        sum_d = sum_q + x_ext_s - old_ext_s;
`ifdef MYCIRCUIT_ROUND_EN
        res_s = sum_d + BIAS;
`else
        res_s = sum_d;
`endif
        y_d   = DATA_W'(res_s >>> TAPS_LOG2);
    end

    // Delay line, running sum and output register advance together only in CALC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
            end
            sum_q <= '0;
            y_q   <= '0;
        end else if (en_i) begin
            line_q[ptr_i] <= x_i;
            sum_q         <= sum_d;
            y_q           <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/mycircuit.sv
// Stereo boxcar low-pass between codec read and write FIFOs: handshake FSM plus two channels.
// Build macro MYCIRCUIT_ROUND_EN (see mycircuit_avg_chan) changes only the output rounding.
module mycircuit
    import mycircuit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAPS_LOG2 = TAPS_LOG2_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              read_ready,
    input  logic              write_ready,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right
);

    state_e               state_q;
    state_e               state_d;
    logic [TAPS_LOG2-1:0] ptr_q;
    logic [TAPS_LOG2-1:0] ptr_d;
    logic [DATA_W-1:0]    in_l_q;
    logic [DATA_W-1:0]    in_l_d;
    logic [DATA_W-1:0]    in_r_q;
    logic [DATA_W-1:0]    in_r_d;
    logic                 read_q;
    logic                 read_d;
    logic                 write_q;
    logic                 write_d;
    logic                 calc_s;

    assign calc_s = (state_q == CALC);

    // Handshake sequencing; ready inputs only matter in IDLE and WAIT_W.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (read_ready) state_d = READ;
                else            state_d = IDLE;
            end
            READ:   state_d = CALC;
            CALC:   state_d = WAIT_W;
            WAIT_W: begin
                if (write_ready) state_d = WRITE;
                else             state_d = WAIT_W;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input capture on the READ edge, pointer advance on the CALC edge, pulse decode of next state.
    always_comb begin
        in_l_d  = in_l_q;
        in_r_d  = in_r_q;
        ptr_d   = ptr_q;
        if (state_q == READ) begin
            in_l_d = readdata_left;
            in_r_d = readdata_right;
        end else begin
            in_l_d = in_l_q;
            in_r_d = in_r_q;
        end
        if (calc_s) ptr_d = ptr_q + TAPS_LOG2'(1);
        else        ptr_d = ptr_q;
        read_d  = (state_d == READ);
        write_d = (state_d == WRITE);
    end

    // Control and capture registers; pulses are registered copies of the state decode.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            in_l_q  <= '0;
            in_r_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            in_l_q  <= in_l_d;
            in_r_q  <= in_r_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign read  = read_q;
    assign write = write_q;

    mycircuit_avg_chan #(
        .DATA_W    (DATA_W),
        .TAPS_LOG2 (TAPS_LOG2)
    ) u_left (
        .clk_i  (CLOCK_50),
        .rst_ni (reset),
        .en_i   (calc_s),
        .ptr_i  (ptr_q),
        .x_i    (in_l_q),
        .y_o    (writedata_left)
    );

    mycircuit_avg_chan #(
        .DATA_W    (DATA_W),
        .TAPS_LOG2 (TAPS_LOG2)
    ) u_right (
        .clk_i  (CLOCK_50),
        .rst_ni (reset),
        .en_i   (calc_s),
        .ptr_i  (ptr_q),
        .x_i    (in_r_q),
        .y_o    (writedata_right)
    );

endmodule

// File: tb/tb_mycircuit.sv
// Self-checking bench for mycircuit: directed scenarios plus randomized pairs against a queue-based average model.
`timescale 1ns/1ps
module tb_mycircuit;

    localparam int DW   = 24;
    localparam int TL   = 2;
    localparam int TAPS = 4;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          read_ready;
    logic          write_ready;
    logic          read;
    logic          write;
    logic [DW-1:0] readdata_left;
    logic [DW-1:0] readdata_right;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int overlap   = 0;
    int ql[$];
    int qr[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    mycircuit #(.DATA_W(DW), .TAPS_LOG2(TL)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .read_ready      (read_ready),
        .write_ready     (write_ready),
        .read            (read),
        .write           (write),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right)
    );

    always @(negedge CLOCK_50) begin
        if (read)          rd_pulses++;
        if (write)         wr_pulses++;
        if (read && write) overlap++;
    end

    // Mean of the last TAPS inputs, missing history counting as zero.
    function automatic int avg_of(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
`ifdef MYCIRCUIT_ROUND_EN
        return (s + TAPS / 2) >>> TL;
`else
        return s >>> TL;
`endif
    endfunction

    task automatic model_push(input int l, input int r, output logic [DW-1:0] el, output logic [DW-1:0] er);
        int a;
        ql.push_back(l);
        qr.push_back(r);
        if (ql.size() > TAPS) void'(ql.pop_front());
        if (qr.size() > TAPS) void'(qr.pop_front());
        a  = avg_of(ql);
        el = a[DW-1:0];
        a  = avg_of(qr);
        er = a[DW-1:0];
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        read_ready  = 1'b0;
        write_ready = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        ql.delete();
        qr.delete();
    endtask

    // Offer one pair, then collect the written pair; write_ready is held low for 'hold' cycles after the read.
    task automatic run_pair(input int l, input int r, input int hold,
                            output logic [DW-1:0] ol, output logic [DW-1:0] orr,
                            output int wait_rd, output int rd2wr, output bit to);
        to             = 1'b0;
        ol             = '0;
        orr            = '0;
        rd2wr          = 0;
        wait_rd        = 0;
        readdata_left  = l[DW-1:0];
        readdata_right = r[DW-1:0];
        read_ready     = 1'b1;
        write_ready    = (hold == 0);
        while (1) begin
            @(negedge CLOCK_50);
            wait_rd++;
            if (read) break;
            if (wait_rd > 50) begin
                to = 1'b1;
                break;
            end
        end
        read_ready = 1'b0;
        if (!to) begin
            while (1) begin
                @(negedge CLOCK_50);
                rd2wr++;
                if (rd2wr >= hold) write_ready = 1'b1;
                if (write) break;
                if (rd2wr > 100) begin
                    to = 1'b1;
                    break;
                end
            end
            ol  = writedata_left;
            orr = writedata_right;
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset          = 1'b0;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        readdata_left  = 24'd5;
        readdata_right = 24'd7;
        repeat (3) @(negedge CLOCK_50);
        n_checks++; if (read !== 1'b0) $display("FAIL reset_read: got %b want 0", read); else n_pass++;
        n_checks++; if (write !== 1'b0) $display("FAIL reset_write: got %b want 0", write); else n_pass++;
        n_checks++; if (writedata_left !== 24'd0) $display("FAIL reset_wl: got %0d want 0", writedata_left); else n_pass++;
        n_checks++; if (writedata_right !== 24'd0) $display("FAIL reset_wr: got %0d want 0", writedata_right); else n_pass++;
        reset = 1'b1;
        cnt   = 0;
        while (cnt <= 20) begin
            @(negedge CLOCK_50);
            cnt++;
            if (read) break;
        end
        n_checks++; if (cnt !== 1) $display("FAIL reset_first_read: got %0d cycles want 1", cnt); else n_pass++;
        do_reset();
    endtask

    task automatic test_stream();
        int exp_tab[8] = '{16, 48, 96, 160, 160, 160, 160, 160};
        logic [DW-1:0] ol, orr, el, er, ex;
        int w, d, prev_d, rd0, wr0;
        bit to;
        do_reset();
        rd0    = rd_pulses;
        wr0    = wr_pulses;
        prev_d = 0;
        for (int i = 0; i < 8; i++) begin
            int v = 64 * ((i % 4) + 1);
            run_pair(v, v, 0, ol, orr, w, d, to);
            model_push(v, v, el, er);
            ex = exp_tab[i][DW-1:0];
            n_checks++; if (to) $display("FAIL stream_timeout[%0d]: got timeout want handshake", i); else n_pass++;
            n_checks++; if (ol !== ex || ol !== el) $display("FAIL stream_l[%0d]: got %0d want %0d", i, $signed(ol), $signed(ex)); else n_pass++;
            n_checks++; if (orr !== ex || orr !== er) $display("FAIL stream_r[%0d]: got %0d want %0d", i, $signed(orr), $signed(ex)); else n_pass++;
            n_checks++; if (d !== 3) $display("FAIL stream_latency[%0d]: got %0d want 3", i, d); else n_pass++;
            if (i > 0) begin
                n_checks++; if (w + prev_d !== 5) $display("FAIL stream_spacing[%0d]: got %0d want 5", i, w + prev_d); else n_pass++;
            end
            prev_d = d;
        end
        @(negedge CLOCK_50);
        n_checks++; if (rd_pulses - rd0 !== 8) $display("FAIL stream_reads: got %0d want 8", rd_pulses - rd0); else n_pass++;
        n_checks++; if (wr_pulses - wr0 !== 8) $display("FAIL stream_writes: got %0d want 8", wr_pulses - wr0); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] el, er, held;
        int viol, cnt;
        do_reset();
        readdata_left  = 24'd100;
        readdata_right = 24'hFFFF9C;
        read_ready     = 1'b1;
        write_ready    = 1'b0;
        cnt = 0;
        while (cnt <= 50) begin
            @(negedge CLOCK_50);
            cnt++;
            if (read) break;
        end
        n_checks++; if (!read) $display("FAIL bp_read_timeout: got no read want read"); else n_pass++;
        repeat (2) @(negedge CLOCK_50);
        model_push(100, -100, el, er);
        held = writedata_left;
        n_checks++; if (held !== el) $display("FAIL bp_value: got %0d want %0d", $signed(held), $signed(el)); else n_pass++;
        n_checks++; if (writedata_right !== er) $display("FAIL bp_value_r: got %0d want %0d", $signed(writedata_right), $signed(er)); else n_pass++;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (write || read || writedata_left !== held) viol++;
        end
        n_checks++; if (viol !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", viol); else n_pass++;
        write_ready = 1'b1;
        @(negedge CLOCK_50);
        n_checks++; if (write !== 1'b1) $display("FAIL bp_write: got %b want 1", write); else n_pass++;
        n_checks++; if (writedata_left !== el) $display("FAIL bp_write_val: got %0d want %0d", $signed(writedata_left), $signed(el)); else n_pass++;
        @(negedge CLOCK_50);
        n_checks++; if (write !== 1'b0 || read !== 1'b0) $display("FAIL bp_idle: got write=%b read=%b want 0 0", write, read); else n_pass++;
        @(negedge CLOCK_50);
        n_checks++; if (read !== 1'b1) $display("FAIL bp_next_read: got %b want 1", read); else n_pass++;
        read_ready = 1'b0;
        cnt = 0;
        while (cnt <= 50) begin
            @(negedge CLOCK_50);
            cnt++;
            if (write) break;
        end
        model_push(100, -100, el, er);
        n_checks++; if (writedata_left !== el || writedata_right !== er)
            $display("FAIL bp_second: got %0d/%0d want %0d/%0d", $signed(writedata_left), $signed(writedata_right), $signed(el), $signed(er));
        else n_pass++;
    endtask

    task automatic test_channels();
        logic [DW-1:0] ol, orr, el, er;
        int w, d;
        bit to;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_pair(1000, -8, 0, ol, orr, w, d, to);
            model_push(1000, -8, el, er);
            if (i == 0) begin
                n_checks++; if (ol !== 24'd250) $display("FAIL chan_first_l: got %0d want 250", $signed(ol)); else n_pass++;
                n_checks++; if (orr !== 24'hFFFFFE) $display("FAIL chan_first_r: got %0d want -2", $signed(orr)); else n_pass++;
            end else if (i == 3) begin
                n_checks++; if (ol !== 24'd1000) $display("FAIL chan_full_l: got %0d want 1000", $signed(ol)); else n_pass++;
                n_checks++; if (orr !== 24'hFFFFF8) $display("FAIL chan_full_r: got %0d want -8", $signed(orr)); else n_pass++;
            end else begin
                n_checks++; if (ol !== el || orr !== er)
                    $display("FAIL chan_mid[%0d]: got %0d/%0d want %0d/%0d", i, $signed(ol), $signed(orr), $signed(el), $signed(er));
                else n_pass++;
            end
        end
    endtask

    task automatic test_truncation();
        logic [DW-1:0] ol, orr, el, er, first;
        int w, d;
        bit to;
`ifdef MYCIRCUIT_ROUND_EN
        first = 24'd1;
`else
        first = 24'd0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_pair(3, 3, 0, ol, orr, w, d, to);
            model_push(3, 3, el, er);
            if (i == 0) begin
                n_checks++; if (ol !== first || orr !== first) $display("FAIL trunc_first: got %0d/%0d want %0d", ol, orr, first); else n_pass++;
            end else begin
                n_checks++; if (ol !== el || orr !== er) $display("FAIL trunc[%0d]: got %0d/%0d want %0d/%0d", i, ol, orr, el, er); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ol, orr, el, er;
        int w, d, cnt;
        bit to;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_pair(64 * (i + 1), 64 * (i + 1), 0, ol, orr, w, d, to);
            model_push(64 * (i + 1), 64 * (i + 1), el, er);
        end
        n_checks++; if (ol !== 24'd160) $display("FAIL mid_pre: got %0d want 160", ol); else n_pass++;
        readdata_left  = 24'd64;
        readdata_right = 24'd64;
        read_ready     = 1'b1;
        write_ready    = 1'b0;
        cnt = 0;
        while (cnt <= 50) begin
            @(negedge CLOCK_50);
            cnt++;
            if (read) break;
        end
        read_ready = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        n_checks++; if (writedata_left !== 24'd160) $display("FAIL mid_wait_val: got %0d want 160", writedata_left); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (writedata_left !== 24'd0 || writedata_right !== 24'd0)
            $display("FAIL mid_reset_out: got %0d/%0d want 0/0", writedata_left, writedata_right);
        else n_pass++;
        n_checks++; if (read !== 1'b0 || write !== 1'b0) $display("FAIL mid_reset_pulse: got read=%b write=%b want 0 0", read, write); else n_pass++;
        @(negedge CLOCK_50);
        reset = 1'b1;
        ql.delete();
        qr.delete();
        run_pair(64, 64, 0, ol, orr, w, d, to);
        model_push(64, 64, el, er);
        n_checks++; if (ol !== 24'd16 || orr !== 24'd16 || ol !== el) $display("FAIL mid_after: got %0d/%0d want 16", ol, orr); else n_pass++;
    endtask

    task automatic test_random();
        logic [DW-1:0] ol, orr, el, er, raw;
        int w, d, l, r;
        bit to;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            raw = DW'($urandom);
            l   = {{8{raw[DW-1]}}, raw};
            raw = DW'($urandom);
            r   = {{8{raw[DW-1]}}, raw};
            run_pair(l, r, $urandom_range(0, 3), ol, orr, w, d, to);
            model_push(l, r, el, er);
            n_checks++; if (to || ol !== el) $display("FAIL rand_l[%0d]: got %0d want %0d", i, $signed(ol), $signed(el)); else n_pass++;
            n_checks++; if (to || orr !== er) $display("FAIL rand_r[%0d]: got %0d want %0d", i, $signed(orr), $signed(er)); else n_pass++;
        end
    endtask

    initial begin
        reset          = 1'b0;
        read_ready     = 1'b0;
        write_ready    = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_channels();
        test_truncation();
        test_reset_mid();
        test_random();
        n_checks++; if (overlap !== 0) $display("FAIL read_write_overlap: got %0d cycles want 0", overlap); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
